// File: rtl/load_store_unit.sv
// Load/store unit between execute and a byte-laned data memory: one access per handshake,
// word-crossing accesses split into two memory cycles, load data assembled and extended.
module load_store_unit #(
   parameter int unsigned ALLOW_MISALIGNED = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   output logic [3:0]  mem_byte_sel,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

   state_t      state;
   logic        lat_store;
   logic [2:0]  lat_funct3;
   logic [1:0]  lat_off;
   logic [7:0]  lat_span;
   logic [31:0] lat_wrot;
   logic [31:0] asm_data;

   function automatic logic [3:0] size_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         2'b10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

   // Byte i moves to lane (i+n) mod 4.
   function automatic logic [31:0] rot_left_bytes(input logic [31:0] d, input logic [1:0] n);
      case (n)
         2'd0:    return d;
         2'd1:    return {d[23:0], d[31:24]};
         2'd2:    return {d[15:0], d[31:16]};
         default: return {d[7:0], d[31:8]};
      endcase
   endfunction

   // Lane (i+n) mod 4 moves to byte i.
   function automatic logic [31:0] rot_right_bytes(input logic [31:0] d, input logic [1:0] n);
      case (n)
         2'd0:    return d;
         2'd1:    return {d[7:0], d[31:8]};
         2'd2:    return {d[15:0], d[31:16]};
         default: return {d[23:0], d[31:24]};
      endcase
   endfunction

   function automatic logic [31:0] byte_swap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
      case (f3)
         3'b000:  return {{24{d[7]}}, d[7:0]};
         3'b001:  return {{16{d[15]}}, d[15:0]};
         3'b100:  return {24'h0, d[7:0]};
         3'b101:  return {16'h0, d[15:0]};
         default: return d;
      endcase
   endfunction

   // Lane enables of both accesses as one 8-bit span: [3:0] first word, [7:4] second word.
   logic [7:0]  req_span;
   logic        req_split;
   logic        req_illegal;
   logic        req_bad;
   logic [31:0] req_wrot;
   logic [31:0] rd_lanes;
   logic [31:0] acc0_bytes;
   logic [31:0] acc1_bytes;

   always_comb begin
      req_span    = {4'b0000, size_mask(req_funct3)} << req_addr[1:0];
      req_split   = |req_span[7:4];
      req_illegal = req_store ? (req_funct3 > 3'd2)
                              : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
      req_bad     = req_illegal | (req_split & (ALLOW_MISALIGNED == 0));
      req_wrot    = rot_left_bytes(req_wdata, req_addr[1:0]);
      // Read bus carries lane 0 in the top byte; normalise so lane k sits at [8k+7:8k].
      rd_lanes    = byte_swap(mem_read_data);
      acc0_bytes  = rot_right_bytes(rd_lanes & lane_mask(lat_span[3:0]), lat_off);
      acc1_bytes  = rot_right_bytes(rd_lanes & lane_mask(lat_span[7:4]), lat_off);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         req_ready        <= 1'b1;
         resp_valid       <= 1'b0;
         resp_err         <= 1'b0;
         resp_rdata       <= 32'h0;
         mem_read_enable  <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_byte_sel     <= 4'h0;
         mem_addr         <= 32'h0;
         mem_write_data   <= 32'h0;
         lat_store        <= 1'b0;
         lat_funct3       <= 3'h0;
         lat_off          <= 2'h0;
         lat_span         <= 8'h0;
         lat_wrot         <= 32'h0;
         asm_data         <= 32'h0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_store  <= req_store;
                  lat_funct3 <= req_funct3;
                  lat_off    <= req_addr[1:0];
                  lat_span   <= req_span;
                  lat_wrot   <= req_wrot;
                  req_ready  <= 1'b0;
                  if (req_bad) begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state            <= ACC0;
                     mem_addr         <= {req_addr[31:2], 2'b00};
                     mem_byte_sel     <= req_span[3:0];
                     mem_write_enable <= req_store;
                     mem_read_enable  <= ~req_store;
                     mem_write_data   <= req_store ? (req_wrot & lane_mask(req_span[3:0])) : 32'h0;
                  end
               end
            end
            ACC0: begin
               if (|lat_span[7:4]) begin
                  state          <= ACC1;
                  asm_data       <= acc0_bytes;
                  mem_addr       <= mem_addr + 32'd4;
                  mem_byte_sel   <= lat_span[7:4];
                  mem_write_data <= lat_store ? (lat_wrot & lane_mask(lat_span[7:4])) : 32'h0;
               end else begin
                  state            <= DONE;
                  resp_valid       <= 1'b1;
                  resp_rdata       <= lat_store ? 32'h0 : extend(acc0_bytes, lat_funct3);
                  mem_read_enable  <= 1'b0;
                  mem_write_enable <= 1'b0;
                  mem_byte_sel     <= 4'h0;
                  mem_addr         <= 32'h0;
                  mem_write_data   <= 32'h0;
               end
            end
            ACC1: begin
               state            <= DONE;
               resp_valid       <= 1'b1;
               resp_rdata       <= lat_store ? 32'h0 : extend(asm_data | acc1_bytes, lat_funct3);
               mem_read_enable  <= 1'b0;
               mem_write_enable <= 1'b0;
               mem_byte_sel     <= 4'h0;
               mem_addr         <= 32'h0;
               mem_write_data   <= 32'h0;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
